// File: rtl/trace_stdout_collector.sv
// trace_stdout_collector: turns per-core retire traces into one tagged character stream.
// Shadows r3 per core and decodes the simulation l.nop putc/exit conventions. Characters
// go through a per-core hold slot and a round-robin arbiter into a valid/ready FIFO.
// Optional feature: define TRACE_STDOUT_REPORT_EN to decode l.nop report (0x15000002),
// which prints r3 as eight uppercase hex digits followed by a newline.

module trace_stdout_collector #(
    parameter int unsigned CORES      = 2,
    parameter int unsigned FIFO_DEPTH = 8,
    parameter int unsigned CORE_W     = (CORES > 1) ? $clog2(CORES) : 1
) (
    input  logic                  clk,
    input  logic                  rst_sys_n,
    input  logic [CORES-1:0]      trace_enable,
    input  logic [32*CORES-1:0]   trace_insn,
    input  logic [CORES-1:0]      trace_wben,
    input  logic [5*CORES-1:0]    trace_wbreg,
    input  logic [32*CORES-1:0]   trace_wbdata,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [7:0]            out_char,
    output logic [CORE_W-1:0]     out_core,
    output logic [CORES-1:0]      termination,
    output logic [32*CORES-1:0]   term_code,
    output logic                  all_terminated,
    output logic [15:0]           dropped_count
);

    localparam int unsigned PTR_W   = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int unsigned ENTRY_W = CORE_W + 8;

    localparam logic [31:0]       InsnExit  = 32'h1500_0001;
    localparam logic [31:0]       InsnPutc  = 32'h1500_0004;
    localparam logic [CORE_W-1:0] LastCore  = CORE_W'(CORES - 1);
    localparam logic [PTR_W:0]    FullCount = (PTR_W + 1)'(FIFO_DEPTH);

    typedef enum logic {StRun, StTerm} core_state_e;

    // Per-core state
    core_state_e       state_q     [CORES];
    logic [31:0]       r3_q        [CORES];
    logic [31:0]       term_code_q [CORES];

    // Hold slots
    logic [CORES-1:0]  slot_valid_q;
`ifdef TRACE_STDOUT_REPORT_EN
    localparam logic [31:0] InsnReport = 32'h1500_0002;
    logic [31:0]       slot_data_q [CORES];
    logic [3:0]        slot_cnt_q  [CORES];
    logic [CORES-1:0]  slot_rep_q;
    logic [CORES-1:0]  rep_ev;
`else
    logic [7:0]        slot_data_q [CORES];
`endif
    logic [7:0]        slot_char   [CORES];
    logic [CORES-1:0]  slot_last;
    logic [CORES-1:0]  slot_busy;
    logic [CORES-1:0]  core_active;
    logic [CORES-1:0]  put_ev;
    logic [CORES-1:0]  exit_ev;
    logic [CORES-1:0]  r3_wr;
    logic [CORES-1:0]  load;
    logic [CORES-1:0]  drop;
    logic [CORES-1:0]  drain;

    // Arbiter
    logic              grant_valid;
    logic [CORE_W-1:0] grant_idx;
    logic [CORE_W-1:0] arb_ptr_q;
    logic [CORE_W-1:0] arb_ptr_d;
    int                arb_idx;

    // Character FIFO
    logic [ENTRY_W-1:0] fifo_mem [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q;
    logic [PTR_W-1:0]   rd_ptr_q;
    logic [PTR_W:0]     count_q;
    logic               push;
    logic               pop;
    logic               full;

    logic [15:0]        dropped_q;
    logic [15:0]        dropped_d;
    logic [16:0]        drop_sum;
    logic               all_term_q;
    logic               all_term_d;

`ifdef TRACE_STDOUT_REPORT_EN
    // cnt 9..2 selects nibble 7..0, so the MSB nibble is printed first.
    function automatic logic [7:0] hex_ascii(input logic [31:0] word, input logic [3:0] cnt);
        logic [2:0] sel;
        logic [3:0] nib;
        sel = 3'(cnt - 4'd2);
        nib = word[{sel, 2'b00} +: 4];
        hex_ascii = (nib < 4'd10) ? (8'h30 + {4'h0, nib}) : (8'h37 + {4'h0, nib});
    endfunction
`endif

    // Character presented by each hold slot and whether this grant empties it
    always_comb begin
        for (int i = 0; i < int'(CORES); i++) begin
            slot_char[i] = 8'h00;
            slot_last[i] = 1'b1;
`ifdef TRACE_STDOUT_REPORT_EN
            if (slot_rep_q[i]) begin
                slot_char[i] = (slot_cnt_q[i] == 4'd1) ? 8'h0A
                                                       : hex_ascii(slot_data_q[i], slot_cnt_q[i]);
                slot_last[i] = (slot_cnt_q[i] == 4'd1);
            end else begin
                slot_char[i] = slot_data_q[i][7:0];
            end
`else
            slot_char[i] = slot_data_q[i];
`endif
        end
    end

    // Round-robin arbiter: search starts at arb_ptr_q, which points past the last grant
    always_comb begin
        grant_valid = 1'b0;
        grant_idx   = '0;
        arb_idx     = 0;
        for (int k = 0; k < int'(CORES); k++) begin
            arb_idx = (int'(arb_ptr_q) + k) % int'(CORES);
            if (!grant_valid && slot_valid_q[arb_idx]) begin
                grant_valid = 1'b1;
                grant_idx   = CORE_W'(arb_idx);
            end
        end
        pop       = out_valid && out_ready;
        full      = (count_q == FullCount);
        push      = grant_valid && (!full || pop);
        arb_ptr_d = arb_ptr_q;
        if (push) begin
            arb_ptr_d = (grant_idx == LastCore) ? '0 : grant_idx + 1'b1;
        end
    end

    // Trace decode; shadow r3 is read before any same-cycle writeback lands
    always_comb begin
        drop_sum = {1'b0, dropped_q};
        for (int i = 0; i < int'(CORES); i++) begin
            core_active[i] = (state_q[i] == StRun) && trace_enable[i];
            put_ev[i]      = core_active[i] && (trace_insn[32*i +: 32] == InsnPutc);
            exit_ev[i]     = core_active[i] && (trace_insn[32*i +: 32] == InsnExit);
            r3_wr[i]       = core_active[i] && trace_wben[i] && (trace_wbreg[5*i +: 5] == 5'd3);
            drain[i]       = push && (grant_idx == CORE_W'(i));
            // A slot finishing its last char this cycle may reload immediately.
            slot_busy[i]   = slot_valid_q[i] && !(drain[i] && slot_last[i]);
`ifdef TRACE_STDOUT_REPORT_EN
            rep_ev[i]      = core_active[i] && (trace_insn[32*i +: 32] == InsnReport);
            load[i]        = (put_ev[i] || rep_ev[i]) && !slot_busy[i];
            drop[i]        = (put_ev[i] || rep_ev[i]) && slot_busy[i];
`else
            load[i]        = put_ev[i] && !slot_busy[i];
            drop[i]        = put_ev[i] && slot_busy[i];
`endif
            if (drop[i]) begin
                drop_sum = drop_sum + 17'd1;
            end
        end
        dropped_d = drop_sum[16] ? 16'hFFFF : drop_sum[15:0];
    end

    // Termination view and global done condition
    always_comb begin
        termination = '0;
        term_code   = '0;
        for (int i = 0; i < int'(CORES); i++) begin
            termination[i]        = (state_q[i] == StTerm);
            term_code[32*i +: 32] = term_code_q[i];
        end
        all_term_d = all_term_q || (&termination && (slot_valid_q == '0) && (count_q == '0));
    end

    // Per-core run/term state machine with shadow r3 and exit code capture
    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            for (int i = 0; i < int'(CORES); i++) begin
                state_q[i]     <= StRun;
                r3_q[i]        <= '0;
                term_code_q[i] <= '0;
            end
        end else begin
            for (int i = 0; i < int'(CORES); i++) begin
                if (exit_ev[i]) begin
                    state_q[i]     <= StTerm;
                    term_code_q[i] <= r3_q[i];
                end
                if (r3_wr[i]) begin
                    r3_q[i] <= trace_wbdata[32*i +: 32];
                end
            end
        end
    end

    // Hold slots: a new load overrides the drain of the char already handed off
    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            slot_valid_q <= '0;
            for (int i = 0; i < int'(CORES); i++) begin
                slot_data_q[i] <= '0;
`ifdef TRACE_STDOUT_REPORT_EN
                slot_cnt_q[i]  <= '0;
`endif
            end
`ifdef TRACE_STDOUT_REPORT_EN
            slot_rep_q <= '0;
`endif
        end else begin
            for (int i = 0; i < int'(CORES); i++) begin
                if (load[i]) begin
                    slot_valid_q[i] <= 1'b1;
`ifdef TRACE_STDOUT_REPORT_EN
                    slot_rep_q[i]   <= rep_ev[i];
                    slot_cnt_q[i]   <= rep_ev[i] ? 4'd9 : 4'd1;
                    slot_data_q[i]  <= rep_ev[i] ? r3_q[i] : {24'h0, r3_q[i][7:0]};
`else
                    slot_data_q[i]  <= r3_q[i][7:0];
`endif
                end else if (drain[i]) begin
                    if (slot_last[i]) begin
                        slot_valid_q[i] <= 1'b0;
                    end
`ifdef TRACE_STDOUT_REPORT_EN
                    else begin
                        slot_cnt_q[i] <= slot_cnt_q[i] - 4'd1;
                    end
`endif
                end
            end
        end
    end

    // FIFO pointers, arbiter pointer, drop counter and sticky done flag
    always_ff @(posedge clk or negedge rst_sys_n) begin
        if (!rst_sys_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            count_q    <= '0;
            arb_ptr_q  <= '0;
            dropped_q  <= '0;
            all_term_q <= 1'b0;
        end else begin
            if (push) begin
                wr_ptr_q <= wr_ptr_q + 1'b1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + 1'b1;
            end
            if (push && !pop) begin
                count_q <= count_q + 1'b1;
            end else if (pop && !push) begin
                count_q <= count_q - 1'b1;
            end
            arb_ptr_q  <= arb_ptr_d;
            dropped_q  <= dropped_d;
            all_term_q <= all_term_d;
        end
    end

    // FIFO storage; contents are don't-care while the count says empty
    always_ff @(posedge clk) begin
        if (push) begin
            fifo_mem[wr_ptr_q] <= {grant_idx, slot_char[grant_idx]};
        end
    end

    assign out_valid      = (count_q != '0);
    assign out_char       = out_valid ? fifo_mem[rd_ptr_q][7:0] : 8'h00;
    assign out_core       = out_valid ? fifo_mem[rd_ptr_q][ENTRY_W-1:8] : '0;
    assign dropped_count  = dropped_q;
    assign all_terminated = all_term_q;

endmodule
